// File: rtl/l2_norm_sqrt_if.sv
// ---------------------------------------------------------------------------
// l2_norm_sqrt_if
// Groups the stream signals between the accumulator (master) and the
// square-root consumer (slave).
//   f          master->slave  IN_W     sum-of-squares word
//   valid_in   master->slave  1        f valid this cycle (no ready)
//   root       slave->master  OUT_W+1  integer square root, held between pulses
//   valid_out  slave->master  1        one-cycle pulse, root valid
//   busy       slave->master  1        engine computing or input buffer non-empty
//   overflow   slave->master  1        sticky: an input word was dropped
//   state_dbg  slave->master  1        engine FSM state (0 = IDLE, 1 = CALC)
// Handshake: valid_in has no ready; every word with valid_in=1 is captured
// on that rising edge or dropped (raising overflow) when the buffer is full.
// valid_out is a single-cycle qualifier for root; nothing acknowledges it.
// ---------------------------------------------------------------------------
interface l2_norm_sqrt_if #(
  parameter int IN_W  = 20,
  parameter int OUT_W = IN_W / 2
);
  logic [IN_W-1:0]  f;
  logic             valid_in;
  logic [OUT_W:0]   root;
  logic             valid_out;
  logic             busy;
  logic             overflow;
  logic             state_dbg;

  modport master (
    output f, valid_in,
    input  root, valid_out, busy, overflow, state_dbg
  );

  modport slave (
    input  f, valid_in,
    output root, valid_out, busy, overflow, state_dbg
  );
endinterface

// File: rtl/l2_norm_sqrt.sv
// ---------------------------------------------------------------------------
// l2_norm_sqrt
// Integer square root of each sum-of-squares word from the L2-norm
// accumulator. Words are captured into a small FIFO (the source cannot be
// stalled) and a digit-by-digit engine resolves one root bit per cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    l2_norm_sqrt_if.slave (f/valid_in in; root/valid_out/busy/
//          overflow/state_dbg out)
//
// Build option:
//   L2_SQRT_ROUND_EN  defined: result rounded to nearest (may reach 2^OUT_W,
//                     using root[OUT_W]); undefined: floor(sqrt(f)).
//                     Timing is identical in both builds.
// ---------------------------------------------------------------------------
module l2_norm_sqrt #(
  parameter int IN_W       = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  l2_norm_sqrt_if.slave   bus
);
  localparam int OUT_W = IN_W / 2;
  localparam int REM_W = OUT_W + 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(OUT_W);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_e;

  state_e             state_q, state_d;

  // Input FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [IN_W-1:0]    mem_q [FIFO_DEPTH];
  logic [IN_W-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;

  // Engine registers.
  logic [IN_W-1:0]    rad_q, rad_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [OUT_W-1:0]   root_q, root_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Output registers.
  logic [OUT_W:0]     root_out_q, root_out_d;
  logic               valid_out_q, valid_out_d;
  logic               overflow_q, overflow_d;

  logic               fifo_empty, fifo_full, push, pop;
  logic [REM_W-1:0]   rem_shift, trial, rem_next;
  logic [OUT_W-1:0]   root_next;
  logic [OUT_W:0]     final_root;
  logic               ge;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // The engine only takes a word while idle; a pop on the same edge frees a
  // slot, so a full FIFO still accepts the incoming word in that case.
  assign pop  = (state_q == IDLE) && !fifo_empty;
  assign push = bus.valid_in && (!fifo_full || pop);

  // One restoring-sqrt step. The top two bits of rem_q are always zero
  // (rem <= 2*root), so truncating the shifted remainder loses nothing.
  assign rem_shift = REM_W'({rem_q, rad_q[IN_W-1 -: 2]});
  assign trial     = {root_q, 2'b01};
  assign ge        = (rem_shift >= trial);
  assign rem_next  = ge ? (rem_shift - trial) : rem_shift;
  assign root_next = {root_q[OUT_W-2:0], ge};

`ifdef L2_SQRT_ROUND_EN
  // f > r^2 + r  <=>  f >= (r + 0.5)^2 for integers, i.e. round half up.
  assign final_root = (rem_next > REM_W'(root_next)) ?
                      ({1'b0, root_next} + (OUT_W+1)'(1)) : {1'b0, root_next};
`else
  assign final_root = {1'b0, root_next};
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty)   state_d = CALC;
      CALC:    if (cnt_q == '0)   state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath / output logic.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    root_out_d  = root_out_q;
    valid_out_d = 1'b0;
    overflow_d  = overflow_q;

    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = bus.f;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (bus.valid_in && !push) overflow_d = 1'b1;

    if (pop) begin
      rad_d    = mem_q[rd_ptr_q[PTR_W-1:0]];
      rem_d    = '0;
      root_d   = '0;
      cnt_d    = CNT_W'(OUT_W - 1);
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end

    if (state_q == CALC) begin
      rem_d  = rem_next;
      root_d = root_next;
      rad_d  = rad_q << 2;
      cnt_d  = cnt_q - CNT_W'(1);
      if (cnt_q == '0) begin
        root_out_d  = final_root;
        valid_out_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      root_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      root_out_q  <= root_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.root      = root_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = (state_q == CALC) || !fifo_empty;
  assign bus.state_dbg = state_q;

endmodule
